// File: rtl/quad_encoder_gen_pkg.sv
// ---------------------------------------------------------------------------
// quad_gen_pkg
// Shared constants for the quadrature encoder emulator.
//   ST_IDLE / ST_RUN       : FSM state codes
//   DIR_FWD / DIR_REV      : stored direction bit (FWD = A leads B)
//   PHASE_AB_TABLE         : phase index -> {A,B} mapping, 2 bits per phase
//   phase_to_ab()          : table lookup helper
// ---------------------------------------------------------------------------
package quad_gen_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Gray sequence: phase 0=00, 1=10, 2=11, 3=01 (packed, phase 0 in LSBs)
    localparam logic [7:0] PHASE_AB_TABLE = 8'b01_11_10_00;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        return PHASE_AB_TABLE[{ph, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/quad_encoder_gen_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Loadable down-counter producing a one-cycle tick every (reload+1) enabled
// clocks.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_val as both the current count and reload value
//   load_val   : count to start from / reload with
//   en         : count enable; tick is only produced while enabled
//   tick       : high in a cycle where the enabled count has reached zero
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_q, reload_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// ---------------------------------------------------------------------------
// quad_encoder_gen
// Quadrature A/B encoder emulator. Accepts signed step commands over a
// valid/ready handshake and emits one Gray-coded edge every cmd_period clocks.
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE, not in reset)
//   cmd_steps         : signed edge count, sign selects direction
//   cmd_period        : clocks per edge, 0 treated as 1
//   abort             : cancel the running command (no done pulse)
//   enc_a, enc_b      : registered quadrature outputs
//   busy              : command in progress
//   done              : one-cycle pulse on normal completion
//   position          : signed net edges emitted since reset (wrapping)
// ---------------------------------------------------------------------------
module quad_encoder_gen
    import quad_gen_pkg::*;
#(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 16,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic              enc_a,
    output logic              enc_b,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [1:0]        ab_q, ab_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;

    logic              accept;
    logic              steps_neg;
    logic [STEP_W-1:0] steps_abs;
    logic [DIV_W-1:0]  reload_val;
    logic              div_en;
    logic              tick;

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // Magnitude is kept unsigned so the most negative command (-2^(W-1))
    // maps to 2^(W-1) edges rather than overflowing.
    assign steps_neg = cmd_steps[STEP_W-1];
    assign steps_abs = steps_neg ? (~cmd_steps + STEP_W'(1)) : cmd_steps;

    // Reload is P-1 with P = max(cmd_period, 1).
    assign reload_val = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);

    // Abort masks the divider enable so a coinciding tick never lands.
    assign div_en = (state_q == ST_RUN) && !abort;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (reload_val),
        .en       (div_en),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                dir_d = steps_neg ? DIR_REV : DIR_FWD;
                rem_d = steps_abs;
                if (steps_abs == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            if (abort) begin
                state_d = ST_IDLE;
            end else if (tick) begin
                if (dir_q == DIR_FWD) begin
                    phase_d = phase_q + 2'd1;
                    pos_d   = pos_q + POS_W'(1);
                end else begin
                    phase_d = phase_q - 2'd1;
                    pos_d   = pos_q - POS_W'(1);
                end
                rem_d = rem_q - STEP_W'(1);
                if (rem_q == STEP_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        // A/B come straight from a flop so the pins cannot glitch.
        ab_d = phase_to_ab(phase_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            ab_q    <= 2'b00;
            pos_q   <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_FWD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign enc_a    = ab_q[1];
    assign enc_b    = ab_q[0];
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign position = pos_q;

endmodule
